// File: rtl/seg_pkg.sv
// Shared constants for the segment-scan decoder: the 16 active-low segment
// patterns (bit0=a .. bit6=g), the FSM state type and default parameters.
package seg_pkg;

  localparam int unsigned NDIG_DEF       = 8;
  localparam int unsigned STABLE_CYC_DEF = 4;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Indexed by the nibble value each pattern represents.
  localparam logic [6:0] SEG_PAT [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef logic [1:0] seg_state_t;
  localparam seg_state_t ST_IDLE   = 2'd0;
  localparam seg_state_t ST_TRACK  = 2'd1;
  localparam seg_state_t ST_LOCKED = 2'd2;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern decoder: seg_n -> {nibble, invalid}.
// Unknown patterns decode to nibble 0 with invalid set.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       invalid
);

  // Table search over the 16 legal patterns.
  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg_n == SEG_PAT[i]) begin
        nibble  = 4'(i);
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment display snooper. Tracks the scanner's digit select
// and segment buses, accepts a digit after STABLE_CYC identical cycles,
// assembles NDIG digits into a frame and hands it out with valid/ready.
// Optional per-digit invalid-pattern flags: define SEG_SCAN_ERR_EN.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned NDIG       = NDIG_DEF,
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an_n,
  input  logic [6:0]        seg_n,
  output logic [4*NDIG-1:0] frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
`ifdef SEG_SCAN_ERR_EN
  output logic [NDIG-1:0]   digit_err,
`endif
  output logic              overflow
);

  localparam logic [7:0] STABLE_Q = 8'(STABLE_CYC);

  logic [NDIG-1:0]   sel_mask;
  logic              sel_valid;
  logic [3:0]        nibble;
  logic              invalid;
  logic [3:0]        cap_nib;
  logic [NDIG+6:0]   scan;
  logic [NDIG+6:0]   scan_q;
  logic              changed;
  seg_state_t        state;
  seg_state_t        state_d;
  logic [7:0]        cnt;
  logic [7:0]        cnt_d;
  logic              capture;
  logic [NDIG-1:0]   seen;
  logic [4*NDIG-1:0] wbuf;
  logic              complete;
`ifdef SEG_SCAN_ERR_EN
  logic [NDIG-1:0]   werr;
`endif

  // A selection is valid only when exactly one digit line is pulled low.
  assign sel_mask  = ~an_n;
  assign sel_valid = (sel_mask != '0) && ((sel_mask & (sel_mask - NDIG'(1))) == '0);

  seg_pattern_decode u_decode (
    .seg_n   (seg_n),
    .nibble  (nibble),
    .invalid (invalid)
  );

  assign cap_nib  = invalid ? 4'h0 : nibble;
  assign scan     = {an_n, seg_n};
  assign changed  = (scan != scan_q);
  assign complete = &seen;

  // Stability tracking: any bus change restarts the count, a full run locks.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    if (changed || state == ST_IDLE) begin
      if (sel_valid) begin
        cnt_d   = 8'd1;
        state_d = ST_TRACK;
        if (STABLE_Q <= 8'd1) begin
          capture = 1'b1;
          state_d = ST_LOCKED;
        end
      end else begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end else if (state == ST_TRACK) begin
      cnt_d = cnt + 8'd1;
      if (cnt_d == STABLE_Q) begin
        capture = 1'b1;
        state_d = ST_LOCKED;
      end
    end else if (state != ST_LOCKED) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
    end
  end

  // FSM state, stability counter and previous-cycle bus snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      scan_q <= '1;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      scan_q <= scan;
    end
  end

  // Working buffer: captures land at the selected index; a completed frame
  // clears the seen mask on the same edge a new capture may set one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
      wbuf <= '0;
`ifdef SEG_SCAN_ERR_EN
      werr <= '0;
`endif
    end else begin
      seen <= (complete ? '0 : seen) | (capture ? sel_mask : '0);
      if (capture) begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (sel_mask[i]) begin
            wbuf[4*i +: 4] <= cap_nib;
`ifdef SEG_SCAN_ERR_EN
            werr[i] <= invalid;
`endif
          end
        end
      end
    end
  end

  // Output holding register with valid/ready handshake and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
`ifdef SEG_SCAN_ERR_EN
      digit_err   <= '0;
`endif
    end else if (complete) begin
      if (!frame_valid || frame_ready) begin
        frame_data  <= wbuf;
        frame_valid <= 1'b1;
`ifdef SEG_SCAN_ERR_EN
        digit_err   <= werr;
`endif
      end else begin
        overflow <= 1'b1;
      end
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (NDIG=8, STABLE_CYC=4) with a
// behavioural reference model compared on every falling clock edge.
module tb_seg_scan_decoder;
  import seg_pkg::*;

  localparam int unsigned ND = 8;
  localparam int unsigned SC = 4;

  logic          clk;
  logic          rst_n;
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
  logic [4*ND-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          overflow;
`ifdef SEG_SCAN_ERR_EN
  logic [ND-1:0] digit_err;
`endif

  seg_scan_decoder #(.NDIG(ND), .STABLE_CYC(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
`ifdef SEG_SCAN_ERR_EN
    .digit_err   (digit_err),
`endif
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spec decode table, indexed by digit value.
  logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a digit is accepted when its {an_n,seg_n} sample has
  // been seen for exactly SC consecutive cycles with one digit selected;
  // a full seen set publishes the frame on the following edge.
  logic [4*ND-1:0] m_data;
  logic            m_valid;
  logic            m_over;
  logic [ND-1:0]   m_err;
  logic [ND-1:0]   m_seen;
  logic [4*ND-1:0] m_buf;
  logic [ND-1:0]   m_ebuf;
  logic            m_pend;
  logic [ND+6:0]   m_last;
  int              m_run;

  always @(posedge clk or negedge rst_n) begin : model
    logic [4*ND-1:0] d, b;
    logic [ND-1:0]   e, s, eb;
    logic            v, o, p;
    logic [ND+6:0]   smp;
    int              run, idx, val;
    if (!rst_n) begin
      m_data <= '0; m_valid <= 1'b0; m_over <= 1'b0; m_err <= '0;
      m_seen <= '0; m_buf <= '0; m_ebuf <= '0; m_pend <= 1'b0;
      m_last <= '0; m_run <= 0;
    end else begin
      d = m_data; v = m_valid; o = m_over; e = m_err;
      s = m_seen; b = m_buf; eb = m_ebuf; p = m_pend;
      smp = {an_n, seg_n};
      if (p) begin
        if (!v || frame_ready) begin
          d = b; e = eb; v = 1'b1;
        end else begin
          o = 1'b1;
        end
        s = '0;
      end else if (v && frame_ready) begin
        v = 1'b0;
      end
      run = (m_run > 0 && smp == m_last) ? m_run + 1 : 1;
      if (run == SC && $countones(~an_n) == 1) begin
        idx = 0;
        for (int k = 0; k < ND; k++) if (!an_n[k]) idx = k;
        val = -1;
        for (int k = 0; k < 16; k++) if (seg_n == PAT[k]) val = k;
        b[4*idx +: 4] = (val < 0) ? 4'h0 : 4'(val);
        eb[idx] = (val < 0);
        s[idx] = 1'b1;
      end
      p = &s;
      m_data <= d; m_valid <= v; m_over <= o; m_err <= e;
      m_seen <= s; m_buf <= b; m_ebuf <= eb; m_pend <= p;
      m_last <= smp; m_run <= run;
    end
  end

  int              hi_cnt = 0;
  logic [4*ND-1:0] last_frame = '0;
  logic [ND-1:0]   last_err = '0;

  // Compare DUT against the model every cycle; log each valid frame seen.
  always @(negedge clk) begin
    chk("frame_valid", 64'(frame_valid), 64'(m_valid));
    chk("frame_data", 64'(frame_data), 64'(m_data));
    chk("overflow", 64'(overflow), 64'(m_over));
`ifdef SEG_SCAN_ERR_EN
    chk("digit_err", 64'(digit_err), 64'(m_err));
`endif
    if (frame_valid) begin
      hi_cnt     <= hi_cnt + 1;
      last_frame <= frame_data;
`ifdef SEG_SCAN_ERR_EN
      last_err   <= digit_err;
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic show(input int idx, input logic [6:0] pat, input int n);
    an_n  = ~(8'd1 << idx);
    seg_n = pat;
    step(n);
  endtask

  task automatic idle(input int n);
    an_n  = '1;
    seg_n = '1;
    step(n);
  endtask

  int h0;

  initial begin
    rst_n = 1'b1; an_n = '1; seg_n = '1; frame_ready = 1'b1;
    #1 rst_n = 1'b0;
    step(3);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame_data", 64'(frame_data), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Full frame 1..8, consumer always ready.
    h0 = hi_cnt;
    for (int i = 0; i < 8; i++) show(i, PAT[i+1], 6);
    idle(3);
    chk("t030_pulse_len", 64'(hi_cnt - h0), 64'd1);
    chk("t030_data", 64'(last_frame), 64'h87654321);
    chk("t030_model_data", 64'(m_data), 64'h87654321);

    // Digits held one cycle short of the stability threshold.
    h0 = hi_cnt;
    for (int i = 0; i < 8; i++) show(i, PAT[i], 3);
    idle(3);
    chk("t031_no_frame", 64'(hi_cnt - h0), 64'd0);
    chk("t031_valid_low", 64'(frame_valid), 64'd0);

    // Blank pattern on digit 2.
    for (int i = 0; i < 8; i++) show(i, (i == 2) ? 7'h7F : PAT[i], 6);
    idle(3);
    chk("t032_data", 64'(last_frame), 64'h76543010);
`ifdef SEG_SCAN_ERR_EN
    chk("t032_digit_err", 64'(last_err), 64'h04);
`endif

    // Two digits selected at once.
    h0 = hi_cnt;
    an_n = 8'hFC; seg_n = PAT[8];
    step(10);
    chk("t034_state_idle", 64'(dut.state), 64'(ST_IDLE));
    idle(2);
    chk("t034_no_frame", 64'(hi_cnt - h0), 64'd0);

    // Back-pressure: second frame dropped, first held.
    frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) show(i, PAT[i+8], 6);
    for (int i = 0; i < 8; i++) show(i, PAT[i], 6);
    idle(3);
    chk("t033_held_data", 64'(frame_data), 64'hFEDCBA98);
    chk("t033_overflow", 64'(overflow), 64'd1);
    chk("t033_valid_held", 64'(frame_valid), 64'd1);
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t033_valid_drop", 64'(frame_valid), 64'd0);
    step(1);

    // Reset mid-frame discards partial capture and clears overflow.
    for (int i = 0; i < 5; i++) show(i, PAT[1], 6);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    chk("t035_overflow_clr", 64'(overflow), 64'd0);
    h0 = hi_cnt;
    for (int i = 5; i < 8; i++) show(i, PAT[i], 6);
    idle(3);
    chk("t035_partial_no_frame", 64'(hi_cnt - h0), 64'd0);
    for (int i = 0; i < 5; i++) show(i, PAT[10+i], 6);
    idle(3);
    chk("t035_frame_count", 64'(hi_cnt - h0), 64'd1);
    chk("t035_data", 64'(last_frame), 64'h765EDCBA);
    chk("t035_overflow", 64'(overflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter NDIG, default 8, number of scanned digit positions (2..16).
REQ-002 Parameter STABLE_CYC, default 4, consecutive identical cycles required before a digit is accepted (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 an_n  input  NDIG  digit-select bus from the display scanner, active-low, bit i selects digit i.
REQ-006 seg_n  input  7  segment bus, active-low, bit0=a .. bit6=g.
REQ-007 frame_data  output  4*NDIG  captured frame, nibble i at bits [4i+3:4i].
REQ-008 frame_valid  output  1  frame_data holds an unconsumed frame.
REQ-009 frame_ready  input  1  consumer accepts frame on the cycle frame_valid and frame_ready are both 1.
REQ-010 digit_err  output  NDIG  per-digit invalid-pattern flags for the held frame (present only with SEG_SCAN_ERR_EN).
REQ-011 overflow  output  1  sticky, set when a completed frame is dropped.

Function
REQ-012 Selection SHALL be valid only when exactly one bit of an_n is 0; any other value is "no selection".
REQ-013 Decode table (seg_n -> nibble) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F; any other pattern decodes to 0 and is invalid.
REQ-014 FSM states: IDLE (no selection), TRACK (counting stability), LOCKED (digit accepted, awaiting change).
REQ-015 IDLE->TRACK on valid selection, stability counter loaded with 1.
REQ-016 In TRACK, if {an_n,seg_n} equals previous cycle, counter increments; on reaching STABLE_CYC the digit SHALL be captured and state -> LOCKED.
REQ-017 In TRACK or LOCKED, any change of {an_n,seg_n} SHALL restart TRACK (counter=1) if still a valid selection, else -> IDLE.
REQ-018 Capture writes the nibble and invalid flag into the working buffer at the selected index and sets its seen bit; re-capture of an already-seen digit overwrites without error.
REQ-019 Same-cycle completion: when all NDIG seen bits are set after a capture, the working buffer SHALL be transferred to frame_data/digit_err next edge, frame_valid=1, seen mask cleared.
REQ-020 frame_valid SHALL remain 1 and frame_data stable until handshake; handshake clears frame_valid next cycle.
REQ-021 Completion while frame_valid=1 and frame_ready=0: new frame dropped, held frame unchanged, overflow set.
REQ-022 Completion coincident with handshake: new frame loaded, frame_valid stays 1, no overflow.
REQ-023 Capture latency: frame_valid rises one cycle after the capturing cycle of the final digit.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, counter 0, seen mask 0, working buffer 0, frame_data 0, digit_err 0, frame_valid 0, overflow 0.
REQ-025 Reset mid-frame SHALL discard all partially captured digits; overflow clears only on reset.

Configuration
REQ-026 Macro SEG_SCAN_ERR_EN defined: digit_err port and per-digit invalid flags exist per REQ-013/018/019.
REQ-027 Macro absent: digit_err port and flag storage omitted; invalid patterns silently decode to 0; all other behaviour identical.

Structure
REQ-028 Package seg_pkg SHALL hold the 16 segment pattern constants, the FSM state typedef, and default NDIG/STABLE_CYC.
REQ-029 Sub-module seg_pattern_decode SHALL implement the combinational seg_n -> {nibble, invalid} table; seg_scan_decoder instantiates it once.

Verification
REQ-030 Scan digits 0..7 with patterns for 1,2,3,4,5,6,7,8, each held 6 cycles, frame_ready=1 -> frame_data=32'h87654321, frame_valid pulses 1 cycle.
REQ-031 Hold each digit only 3 cycles with STABLE_CYC=4 -> no capture, frame_valid stays 0.
REQ-032 Digit 2 shows 1111111 -> nibble 2 = 0, digit_err=8'h04 (ERR_EN build).
REQ-033 Two full frames, frame_ready=0 -> first frame held, overflow=1; assert frame_ready -> frame_valid drops next cycle.
REQ-034 an_n=8'hFC (two selected) for 10 cycles -> no capture, state IDLE.
REQ-035 rst_n low after 5 digits captured, then full frame -> only post-reset values appear, overflow=0.
